// File: rtl/scs8hd_edfxpipe_pkg.sv
// Shared constants and helpers for the scs8hd_edfxpipe enable/valid pipeline.
// Default and legal-range limits for WIDTH/DEPTH, plus the OCC width function.
package scs8hd_edfxpipe_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 4;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // OCC must count 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/scs8hd_edfxpipe_stage.sv
// One pipeline stage: enable register with valid bit, async active-low reset, sync clear.
// Carries an even-parity bit when SCS8HD_EDFXPIPE_PARITY_EN is defined.
module scs8hd_edfxpipe_stage
    import scs8hd_edfxpipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
    input  logic             dp,
    output logic             qp,
`endif
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    // NOTE: sequential state uses <= so every stage samples its neighbour's old value on the same edge.
    always_ff @(posedge CLK or negedge RESET_B) begin
        // NOTE: data bits are reset along with valid so Q reads 0, not stale data, after reset.
        if (!RESET_B) begin
            q  <= '0;
            qv <= 1'b0;
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
            qp <= 1'b0;
`endif
        end else if (clr) begin
            q  <= '0;
            qv <= 1'b0;
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
            qp <= 1'b0;
`endif
        end else if (en) begin
            q  <= d;
            qv <= dv;
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
            qp <= dp;
`endif
        end
    end

endmodule

// File: rtl/scs8hd_edfxpipe.sv
// DEPTH-stage enable/valid data pipeline with occupancy count and synchronous flush.
// Optional per-stage even parity and QP output under macro SCS8HD_EDFXPIPE_PARITY_EN.
module scs8hd_edfxpipe
    import scs8hd_edfxpipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                        CLK,
    input  logic                        RESET_B,
    input  logic [WIDTH-1:0]            D,
    input  logic                        DV,
    input  logic                        DE,
    input  logic                        CLR,
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
    output logic                        QP,
`endif
    output logic [WIDTH-1:0]            Q,
    output logic                        QV,
    output logic [occ_width(DEPTH)-1:0] OCC
);

    localparam int OW = occ_width(DEPTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("scs8hd_edfxpipe: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("scs8hd_edfxpipe: DEPTH %0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
    end

    logic [WIDTH-1:0] stg_q [DEPTH];
    logic             stg_v [DEPTH];
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
    logic             stg_p [DEPTH];
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
        logic             p_in;
`endif

        if (k == 0) begin : g_head
            assign d_in = D;
            assign v_in = DV;
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
            assign p_in = ^D;
`endif
        end else begin : g_body
            assign d_in = stg_q[k-1];
            assign v_in = stg_v[k-1];
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
            assign p_in = stg_p[k-1];
`endif
        end

        scs8hd_edfxpipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CLK     (CLK),
            .RESET_B (RESET_B),
            .en      (DE),
            .clr     (CLR),
            .d       (d_in),
            .dv      (v_in),
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
            .dp      (p_in),
            .qp      (stg_p[k]),
`endif
            .q       (stg_q[k]),
            .qv      (stg_v[k])
        );
    end

    assign Q  = stg_q[DEPTH-1];
    assign QV = stg_v[DEPTH-1];
`ifdef SCS8HD_EDFXPIPE_PARITY_EN
    assign QP = stg_p[DEPTH-1];
`endif

    // Entry in, exit out: a full pipe with DV=1 nets to zero change, so no saturation is needed.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            OCC <= '0;
        end else if (CLR) begin
            OCC <= '0;
        end else if (DE) begin
            OCC <= OCC + OW'(DV) - OW'(QV);
        end
    end

endmodule
